// File: rtl/tlp_tx_arbiter_if.sv
// Request/grant bundle between the TLP engines and the transmit arbiter.
// The master modport is the arbiter side; engines and benches use slave.
interface tlp_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] active;
  logic               tx_buf_av;
  logic [NUM_REQ-1:0] grant;
  logic [2:0]         grant_id;
  logic               busy;
  logic               timeout;
  logic [2:0]         timeout_id;

  modport master (
    input  req, active, tx_buf_av,
    output grant, grant_id, busy, timeout, timeout_id
  );

  modport slave (
    output req, active, tx_buf_av,
    input  grant, grant_id, busy, timeout, timeout_id
  );
endinterface

// File: rtl/tlp_tx_arbiter.sv
// Round-robin owner arbitration for the endpoint trn_t* transmit port, with an
// ack timeout, a maximum hold time and a fixed idle gap between owners.
module tlp_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ACK_TIMEOUT = 15,
  parameter int unsigned MAX_HOLD    = 1023,
  parameter int unsigned GAP_CYCLES  = 1
) (
  input logic             trn_clk,
  input logic             reset_n,
  tlp_tx_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StWaitAck, StHold, StGap} state_e;

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [2:0]         grant_id_q, grant_id_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [2:0]         timeout_id_q, timeout_id_d;

  logic               arb_hit;
  logic [2:0]         arb_sel;
  logic [NUM_REQ-1:0] arb_oh;
  logic               can_start;
  logic               start, drop, expire;
  logic               own_active, own_req;
  logic [2:0]         ptr_next;

  // grant_q is one-hot on the owner while granted, so masking picks its lines only
  assign own_active = |(bus.active & grant_q);
  assign own_req    = |(bus.req & grant_q);
  assign can_start  = arb_hit && bus.tx_buf_av;
  assign ptr_next   = (grant_id_q == 3'(NUM_REQ - 1)) ? 3'd0 : grant_id_q + 3'd1;

  // Circular scan: indices at or above ptr first, then wrap to those below it.
  always_comb begin
    arb_hit = 1'b0;
    arb_sel = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!arb_hit && j >= 32'(ptr_q) && bus.req[j]) begin
        arb_hit = 1'b1;
        arb_sel = 3'(j);
      end
    end
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (!arb_hit && j < 32'(ptr_q) && bus.req[j]) begin
        arb_hit = 1'b1;
        arb_sel = 3'(j);
      end
    end
    arb_oh = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      arb_oh[j] = (3'(j) == arb_sel);
    end
  end

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      grant_id_q   <= grant_id_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    start   = 1'b0;
    drop    = 1'b0;
    expire  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (can_start) begin
          start   = 1'b1;
          state_d = StWaitAck;
          cnt_d   = '0;
        end
      end
      StWaitAck: begin
        if (own_active) begin
          state_d = StHold;
          cnt_d   = '0;
        end else if (!own_req) begin
          drop = 1'b1;
        end else if (cnt_q == 16'(ACK_TIMEOUT - 1)) begin
          drop   = 1'b1;
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StHold: begin
        if (!own_active) begin
          drop = 1'b1;
        end else if (cnt_q == 16'(MAX_HOLD - 1)) begin
          drop   = 1'b1;
          expire = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StGap: begin
        // The last gap cycle arbitrates so the port is dark for exactly GAP_CYCLES.
        if (cnt_q == 16'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (can_start) begin
            start   = 1'b1;
            state_d = StWaitAck;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (drop) begin
      state_d = StGap;
      cnt_d   = '0;
      ptr_d   = ptr_next;
    end
  end

  always_comb begin
    grant_d      = grant_q;
    grant_id_d   = grant_id_q;
    busy_d       = (state_d != StIdle);
    timeout_d    = 1'b0;
    timeout_id_d = timeout_id_q;
    if (start) begin
      grant_d    = arb_oh;
      grant_id_d = arb_sel;
    end
    if (drop) begin
      grant_d = '0;
    end
    if (expire) begin
      timeout_d    = 1'b1;
      timeout_id_d = grant_id_q;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.busy       = busy_q;
  assign bus.timeout    = timeout_q;
  assign bus.timeout_id = timeout_id_q;

endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// Directed bench for tlp_tx_arbiter: engine models answer grants, a scoreboard
// holds the expected owner, grant length and timeout of each grant episode.
module tb_tlp_tx_arbiter;
  localparam int NR = 4;
  localparam int A  = 15;
  localparam int M  = 1023;
  localparam int G  = 1;

  typedef struct {
    int idx;
    int len;
    bit to;
    int gap;
  } ep_t;

  logic trn_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 trn_clk = ~trn_clk;

  tlp_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  tlp_tx_arbiter #(
    .NUM_REQ    (NR),
    .ACK_TIMEOUT(A),
    .MAX_HOLD   (M),
    .GAP_CYCLES (G)
  ) dut (
    .trn_clk(trn_clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int  checks = 0;
  int  errors = 0;
  ep_t sb[$];
  bit  sb_off = 1'b0;

  // Engine model: want/served give the request level, dly/hld shape the active pulse.
  int want[NR];
  int served[NR];
  int dly[NR];
  int hld[NR];
  bit job[NR];
  int c[NR];
  bit gp[NR];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always_comb begin
    bus.req = '0;
    for (int i = 0; i < NR; i++) bus.req[i] = (served[i] < want[i]);
  end

  always @(negedge trn_clk) begin
    for (int i = 0; i < NR; i++) begin
      if (!job[i] && bus.grant[i] && !gp[i]) begin
        job[i] = 1'b1;
        c[i]   = 0;
      end
      if (job[i]) begin
        if (!bus.grant[i] && c[i] < dly[i]) begin
          job[i]        = 1'b0;
          bus.active[i] = 1'b0;
        end else begin
          bus.active[i] = (c[i] >= dly[i]) && (c[i] < dly[i] + hld[i]);
          c[i]++;
          if (c[i] >= dly[i] + hld[i]) job[i] = 1'b0;
        end
      end else begin
        bus.active[i] = 1'b0;
      end
      if (!bus.grant[i] && gp[i]) served[i]++;
      gp[i] = bus.grant[i];
    end
  end

  // Episode monitor: compares each completed grant against the scoreboard head.
  bit             in_ep = 1'b0;
  int             len;
  int             gap_cnt = -1;
  logic [NR-1:0]  cur_g;
  ep_t            e;

  always @(negedge trn_clk) begin
    if (!reset_n || sb_off) begin
      in_ep   = 1'b0;
      gap_cnt = -1;
    end else begin
      chk("onehot", 32'($onehot0(bus.grant)), 1);
      if (bus.grant != '0) begin
        chk("timeout_while_granted", 32'(bus.timeout), 0);
        if (!in_ep) begin
          in_ep = 1'b1;
          len   = 1;
          cur_g = bus.grant;
          chk("grant_id_matches", 32'(bus.grant), 32'(1) << bus.grant_id);
          chk("sb_nonempty", 32'(sb.size() != 0), 1);
          if (sb.size() != 0 && sb[0].gap >= 0) chk("gap_len", gap_cnt, sb[0].gap);
        end else begin
          len++;
          chk("grant_stable", 32'(bus.grant), 32'(cur_g));
        end
      end else if (in_ep) begin
        in_ep   = 1'b0;
        gap_cnt = 1;
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("owner", 32'(cur_g), 32'(1) << e.idx);
          chk("grant_len", len, e.len);
          chk("timeout", 32'(bus.timeout), 32'(e.to));
          if (e.to) chk("timeout_id", 32'(bus.timeout_id), e.idx);
        end
      end else begin
        if (gap_cnt >= 0) gap_cnt++;
        chk("timeout_idle", 32'(bus.timeout), 0);
      end
    end
  end

  task automatic push(input int i, input int gap);
    ep_t x;
    x.idx = i;
    x.gap = gap;
    if (dly[i] >= A) begin
      x.len = A;
      x.to  = 1'b1;
    end else if (hld[i] >= M + 1) begin
      x.len = dly[i] + M + 1;
      x.to  = 1'b1;
    end else begin
      x.len = dly[i] + hld[i] + 1;
      x.to  = 1'b0;
    end
    sb.push_back(x);
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge trn_clk);
      #1;
      if (sb.size() == 0 && !in_ep) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_done", 32'(ok), 1);
  endtask

  initial begin
    bus.tx_buf_av = 1'b0;
    for (int i = 0; i < NR; i++) begin
      dly[i] = 0;
      hld[i] = 1;
    end
    repeat (3) @(negedge trn_clk);
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_grant_id", 32'(bus.grant_id), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_timeout", 32'(bus.timeout), 0);
    chk("rst_timeout_id", 32'(bus.timeout_id), 0);
    reset_n = 1'b1;

    // No buffer space: requests stall in IDLE, then grant follows tx_buf_av by one edge.
    dly[0] = 0; hld[0] = 3;
    dly[1] = 1; hld[1] = 2;
    want[0]++; want[1]++;
    repeat (20) @(negedge trn_clk);
    chk("stall_grant", 32'(bus.grant), 0);
    chk("stall_busy", 32'(bus.busy), 0);
    push(0, -1);
    push(1, G);
    bus.tx_buf_av = 1'b1;
    @(posedge trn_clk); #1;
    chk("buf_av_grant", 32'(bus.grant), 32'b0001);
    chk("buf_av_busy", 32'(bus.busy), 1);
    wait_done(200);

    // Owner 2 never acks and times out; owner 3 acks on the last allowed cycle.
    dly[2] = 1000; hld[2] = 1;
    dly[3] = A - 1; hld[3] = 2;
    push(2, -1);
    push(3, G);
    want[2]++; want[3]++;
    wait_done(200);

    // Everyone requesting: rotation 0,1,2,3,0 with one dark cycle between owners.
    for (int i = 0; i < NR; i++) begin
      dly[i] = 0; hld[i] = 3;
    end
    push(0, -1); push(1, G); push(2, G); push(3, G); push(0, G);
    want[0] += 2; want[1]++; want[2]++; want[3]++;
    wait_done(300);
    chk("timeout_id_held", 32'(bus.timeout_id), 2);
    chk("grant_id_last", 32'(bus.grant_id), 0);

    // Single requester, one-edge grant latency.
    dly[0] = 2; hld[0] = 5;
    push(0, -1);
    want[0]++;
    @(posedge trn_clk); #1;
    chk("latency_grant", 32'(bus.grant), 32'b0001);
    wait_done(100);
    repeat (2) @(negedge trn_clk);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_grant_id", 32'(bus.grant_id), 0);

    // Hold expiry for owner 1; owner 2 then releases exactly at the expiry edge.
    dly[1] = 0; hld[1] = M + 77;
    dly[2] = 2; hld[2] = M;
    push(1, -1);
    push(2, G);
    want[1]++; want[2]++;
    wait_done(3000);

    // Asynchronous reset in the middle of a hold.
    dly[3] = 0; hld[3] = 20;
    sb_off = 1'b1;
    want[3]++;
    repeat (10) @(negedge trn_clk);
    chk("pre_reset_grant", 32'(bus.grant), 32'b1000);
    #2 reset_n = 1'b0;
    #1;
    chk("async_grant", 32'(bus.grant), 0);
    chk("async_busy", 32'(bus.busy), 0);
    chk("async_timeout", 32'(bus.timeout), 0);
    chk("async_grant_id", 32'(bus.grant_id), 0);
    @(negedge trn_clk);
    @(negedge trn_clk);
    reset_n = 1'b1;
    sb_off  = 1'b0;
    repeat (25) @(negedge trn_clk);
    dly[1] = 0; hld[1] = 3;
    dly[3] = 0; hld[3] = 3;
    push(1, -1);
    push(3, G);
    want[1]++; want[3]++;
    @(posedge trn_clk); #1;
    chk("post_reset_ptr", 32'(bus.grant), 32'b0010);
    wait_done(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
